// File: rtl/game_pkg.sv
// Shared encodings for the rock/paper/scissors game: choices, round results,
// datapath state and the default match length.
package game_pkg;

    localparam logic [1:0] CH_ROCK     = 2'd0;
    localparam logic [1:0] CH_PAPER    = 2'd1;
    localparam logic [1:0] CH_SCISSORS = 2'd2;
    localparam logic [1:0] CH_ILLEGAL  = 2'd3;

    localparam logic [1:0] RES_TIE = 2'd0;
    localparam logic [1:0] RES_P1  = 2'd1;
    localparam logic [1:0] RES_P2  = 2'd2;

    localparam int DEFAULT_WIN_SCORE = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    // Winner from an explicit beats-table rather than modular arithmetic.
    function automatic logic [1:0] round_winner(input logic [1:0] p1, input logic [1:0] p2);
        logic [1:0] res;
        res = RES_TIE;
        case ({p1, p2})
            {CH_PAPER,    CH_ROCK}:     res = RES_P1;
            {CH_SCISSORS, CH_PAPER}:    res = RES_P1;
            {CH_ROCK,     CH_SCISSORS}: res = RES_P1;
            {CH_ROCK,     CH_PAPER}:    res = RES_P2;
            {CH_PAPER,    CH_SCISSORS}: res = RES_P2;
            {CH_SCISSORS, CH_ROCK}:     res = RES_P2;
            default:                    res = RES_TIE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/choice_latch.sv
// Per-player move capture: filters illegal choices, latches the first legal
// move while enabled, and supports a forced rock lock for the round timeout.
module choice_latch
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       drop_i,
    input  logic       enable_i,
    input  logic       force_lock_i,
    input  logic       valid_i,
    input  logic [1:0] choice_i,
    output logic       locked_o,
    output logic [1:0] choice_o
);

    logic       locked_q, locked_d;
    logic [1:0] choice_q, choice_d;

    always_comb begin
        locked_d = locked_q;
        choice_d = choice_q;
        if (drop_i) begin
            locked_d = 1'b0;
            choice_d = CH_ROCK;
        end else if (enable_i && !locked_q) begin
            // A genuine legal strobe wins over a simultaneous forced lock.
            if (valid_i && choice_i != CH_ILLEGAL) begin
                locked_d = 1'b1;
                choice_d = choice_i;
            end else if (force_lock_i) begin
                locked_d = 1'b1;
                choice_d = CH_ROCK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q <= 1'b0;
            choice_q <= CH_ROCK;
        end else begin
            locked_q <= locked_d;
            choice_q <= choice_d;
        end
    end

    assign locked_o = locked_q;
    assign choice_o = choice_q;

endmodule

// File: rtl/round_datapath.sv
// Round datapath: collects both moves, resolves the winner, keeps saturating
// scores. Optional move-collection timeout enabled by ROUND_TIMEOUT_EN.
module round_datapath
    import game_pkg::*;
#(
    parameter int WIN_SCORE      = DEFAULT_WIN_SCORE,
    parameter int SCORE_W        = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               start_round,
    input  logic               p1_valid,
    input  logic [1:0]         p1_choice,
    input  logic               p2_valid,
    input  logic [1:0]         p2_choice,
    output logic               p1_locked,
    output logic               p2_locked,
    output logic               round_ready,
    output logic [8:0]         combo,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               match_over,
    output logic               p1_won
);

    localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_W) || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("round_datapath: WIN_SCORE must fit SCORE_W and TIMEOUT_CYCLES must be >= 2");
    end

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         p1_sel, p2_sel;
    logic [1:0]         winner;
    logic               start_accept, resolve, drop_locks, collecting, timeout_hit;

    assign collecting   = (state_q == ST_COLLECT);
    assign match_over   = (p1_score_q == WIN_Q) || (p2_score_q == WIN_Q);
    assign p1_won       = (p1_score_q == WIN_Q);
    // A finished match parks in READY; only clear/reset can leave it.
    assign start_accept = start_round && !(state_q == ST_READY && match_over);
    assign drop_locks   = clear || start_accept;
    assign resolve      = collecting && p1_locked && p2_locked && !start_round;
    assign winner       = round_winner(p1_sel, p2_sel);

`ifdef ROUND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = collecting && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (drop_locks)
            tmo_cnt_d = '0;
        else if (collecting && !timeout_hit)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    choice_latch u_p1_latch (
        .clk          (clk),
        .reset        (reset),
        .drop_i       (drop_locks),
        .enable_i     (collecting),
        .force_lock_i (timeout_hit),
        .valid_i      (p1_valid),
        .choice_i     (p1_choice),
        .locked_o     (p1_locked),
        .choice_o     (p1_sel)
    );

    choice_latch u_p2_latch (
        .clk          (clk),
        .reset        (reset),
        .drop_i       (drop_locks),
        .enable_i     (collecting),
        .force_lock_i (timeout_hit),
        .valid_i      (p2_valid),
        .choice_i     (p2_choice),
        .locked_o     (p2_locked),
        .choice_o     (p2_sel)
    );

    always_comb begin
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        if (clear) begin
            state_d    = ST_IDLE;
            p1_score_d = '0;
            p2_score_d = '0;
        end else if (start_accept) begin
            state_d = ST_COLLECT;
        end else if (resolve) begin
            state_d = ST_READY;
            if (winner == RES_P1 && p1_score_q != WIN_Q)
                p1_score_d = p1_score_q + 1'b1;
            if (winner == RES_P2 && p2_score_q != WIN_Q)
                p2_score_d = p2_score_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            p1_score_q <= '0;
            p2_score_q <= '0;
        end else begin
            state_q    <= state_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
        end
    end

    assign round_ready  = (state_q == ST_READY);
    assign round_result = round_ready ? winner : RES_TIE;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;

    // One decode per combination input of the controller.
    for (genvar gi = 0; gi < 9; gi++) begin : g_combo
        assign combo[gi] = round_ready
                        && (p1_sel == 2'(gi / 3))
                        && (p2_sel == 2'(gi % 3));
    end

endmodule

// File: doc/round_datapath.md
# round_datapath

Datapath stage feeding the game controller FSM. Collects each player's move (rock/paper/scissors), locks both choices, presents the 3x3 move combination as a one-hot vector (the controller's nine combination inputs), resolves the round winner, and keeps both scores. It also drives the "someone reached the win score" and "player 1 won" status bits the controller samples after each round.

## Interface
Parameters:
- WIN_SCORE, 3, points needed to win the match
- SCORE_W, 2, score counter width; must hold WIN_SCORE
- TIMEOUT_CYCLES, 50000000, move-collection timeout; used only with ROUND_TIMEOUT_EN

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; same effect as clear
- clear  in  1  controller start-screen pulse: zero scores, drop locks, go idle
- start_round  in  1  controller "wait for choices" pulse: open a new round
- p1_valid  in  1  player 1 submits p1_choice this cycle
- p1_choice  in  2  0 rock, 1 paper, 2 scissors, 3 illegal
- p2_valid  in  1  player 2 submit strobe
- p2_choice  in  2  same encoding
- p1_locked, p2_locked  out  1  player's choice is latched for this round
- round_ready  out  1  both choices locked and round resolved
- combo  out  9  one-hot, bit index p1_choice*3+p2_choice; all-zero unless round_ready
- round_result  out  2  0 tie, 1 player 1, 2 player 2; 0 unless round_ready
- p1_score, p2_score  out  SCORE_W  current scores
- match_over  out  1  either score equals WIN_SCORE
- p1_won  out  1  p1_score equals WIN_SCORE

## Operation
- States: IDLE, COLLECT, READY.
- Priority each cycle: reset/clear > start_round > player strobes.
- IDLE: strobes ignored; start_round -> COLLECT.
- COLLECT: pX_valid with choice 0..2 while not yet locked latches the choice and sets pX_locked. Illegal choice (3) and re-submission after lock are ignored. Both players may lock in the same cycle.
- COLLECT with both locks set -> READY on the next edge. The same edge commits the score update.
- Winner rule: (p1-p2) mod 3 == 1 gives player 1 the point; == 2 gives player 2 the point; 0 is a tie with no point.
- Scores saturate at WIN_SCORE and never wrap.
- READY: combo, round_result and round_ready stay stable until start_round or clear.
  - start_round with match_over=0 -> COLLECT, locks cleared, scores kept.
  - start_round with match_over=1 is ignored; only clear leaves the state.
- start_round in COLLECT restarts the round: locks are cleared and no point is awarded.
- match_over and p1_won are decoded combinationally from the score registers.

## Timing
- Reset values: state IDLE, all outputs 0, scores 0.
- Lock latency: pX_locked rises 1 cycle after an accepted strobe.
- Resolution latency: round_ready, combo, round_result and the new scores appear 1 cycle after the second lock is visible (2 cycles after the second strobe).
- match_over is valid in the same cycle as round_ready, so the controller's result state samples a settled value.
- clear or reset in any state takes effect at the next edge and discards a round in flight.

## Configuration
- ROUND_TIMEOUT_EN defined:
  - A cycle counter runs in COLLECT and restarts on every start_round.
  - On reaching TIMEOUT_CYCLES-1, each unlocked player is force-locked with rock (0).
  - Resolution then proceeds normally.
- Undefined: no counter; COLLECT waits indefinitely.

## Structure
- Shared package game_pkg holds:
  - choice encodings CH_ROCK, CH_PAPER, CH_SCISSORS
  - result encodings RES_TIE, RES_P1, RES_P2
  - state enum for IDLE/COLLECT/READY
  - default WIN_SCORE
- Sub-module choice_latch, instantiated once per player: strobe, illegal filter, lock flag, choice register. It has a force-lock input used by the timeout feature.

## Test plan
- Reset, start_round, p1 paper + p2 rock in the same cycle -> 2 cycles later combo bit 3 set, round_result=1, p1_score=1, p2_score=0.
- p1 scissors, then p2 scissors 5 cycles later -> combo bit 8 set, round_result=0, scores unchanged.
- p1 strobe with choice 3, then valid rock; a later p1 strobe with paper -> lock reflects rock only.
- Player 2 wins three rounds -> p2_score=3, match_over=1, p1_won=0. A following start_round is ignored (READY held); clear -> IDLE, scores 0.
- start_round while only p1 is locked -> p1_locked drops, no score change. Reset asserted in READY -> all outputs 0 next cycle.
- ROUND_TIMEOUT_EN with TIMEOUT_CYCLES=8, only p1 locks paper -> p2 forced rock at cycle 8, round_result=1.
